// File: rtl/fb_writer_pkg.sv
// Shared types and helpers for the framebuffer test-pattern writer.
package fb_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PAT_GRADIENT = 2'd0,
    PAT_BARS     = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_FLAT     = 2'd3
  } pattern_t;

  localparam int PIXEL_BYTES = 4;

  // Framebuffer word layout: unused top byte, then R, G, B.
  function automatic logic [31:0] pack_pixel(input logic [23:0] rgb);
    return {8'h00, rgb};
  endfunction

endpackage

// File: rtl/avalon_if.sv
// Avalon-MM bus bundle; host drives the request, agent returns waitrequest/readdata.
interface avalon_if #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 32
);
  logic [ADDR_W-1:0]       address;
  logic                    write;
  logic                    read;
  logic [8*DATA_BYTES-1:0] writedata;
  logic [DATA_BYTES-1:0]   byteenable;
  logic                    waitrequest;
  logic [8*DATA_BYTES-1:0] readdata;

  modport host (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport agent (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/fb_pattern_gen.sv
// Combinational pixel colour generator: (x, y, pattern, flat level) -> 24-bit RGB.
module fb_pattern_gen
  import fb_writer_pkg::*;
#(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  pattern_t      pattern,
  input  logic [7:0]    flat_level,
  output logic [23:0]   rgb
);

  // Patterns only look at x[9:0] and y[7:0]; narrower counters zero-extend.
  logic [9:0] xe;
  logic [7:0] ye;
  logic       unused_bits;

  assign xe          = 10'(x);
  assign ye          = 8'(y);
  assign unused_bits = ^{x, y};

  always_comb begin
    rgb = 24'h000000;
    case (pattern)
      PAT_GRADIENT: rgb = {xe[7:0], ye, 8'h00};
      PAT_BARS:     rgb = {{8{xe[9]}}, {8{xe[8]}}, {8{xe[7]}}};
      PAT_CHECKER:  rgb = (xe[4] ^ ye[4]) ? 24'hFFFFFF : 24'h000000;
      PAT_FLAT:     rgb = {3{flat_level}};
      default:      rgb = 24'h000000;
    endcase
  end

endmodule

// File: rtl/fb_pattern_writer.sv
// Avalon-MM host that fills the framebuffer with a test pattern, one word per pixel.
// Define FB_WRITER_LOOP_EN to keep writing frames back to back while start is held.
module fb_pattern_writer
  import fb_writer_pkg::*;
#(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  avalon_if.host      avalon_ifh,
  input  logic        start,
  input  logic [1:0]  pattern,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_count
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [31:0]   STRIDE = 32'(PIXEL_BYTES);

`ifdef FB_WRITER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_t        state;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  pattern_t      pat_q, pat_n;
  logic [15:0]   fc_n;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic          accept;
  logic          last_px;
  logic          restart;
  logic [23:0]   rgb_n;
  logic          unused_rdata;

  assign accept  = wr_q && !avalon_ifh.waitrequest;
  assign last_px = (x == X_LAST) && (y == Y_LAST);
  assign restart = start && ((state == IDLE) || (LOOP_EN && (state == DONE)));

  // Next pixel coordinates; writedata is generated from these so it is
  // registered alongside address and stays put while waitrequest stalls.
  always_comb begin
    x_n   = x;
    y_n   = y;
    pat_n = pat_q;
    fc_n  = frame_count;
    if (restart) begin
      x_n   = '0;
      y_n   = '0;
      pat_n = pattern_t'(pattern);
    end else if ((state == WRITE) && accept) begin
      if (last_px) begin
        fc_n = frame_count + 16'd1;
      end else if (x == X_LAST) begin
        x_n = '0;
        y_n = y + YW'(1);
      end else begin
        x_n = x + XW'(1);
      end
    end
  end

  fb_pattern_gen #(
    .XW (XW),
    .YW (YW)
  ) u_gen (
    .x          (x_n),
    .y          (y_n),
    .pattern    (pat_n),
    .flat_level (fc_n[7:0]),
    .rgb        (rgb_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_count <= '0;
      x           <= '0;
      y           <= '0;
      pat_q       <= PAT_GRADIENT;
    end else begin
      x           <= x_n;
      y           <= y_n;
      pat_q       <= pat_n;
      frame_count <= fc_n;
      wdata_q     <= pack_pixel(rgb_n);
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (restart) begin
            addr_q <= BASE_ADDR;
            wr_q   <= 1'b1;
            busy   <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          if (accept) begin
            if (last_px) begin
              wr_q  <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              addr_q <= addr_q + STRIDE;
            end
          end
        end
        DONE: begin
          if (restart) begin
            addr_q <= BASE_ADDR;
            wr_q   <= 1'b1;
            busy   <= 1'b1;
            state  <= WRITE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign avalon_ifh.address    = addr_q;
  assign avalon_ifh.write      = wr_q;
  assign avalon_ifh.read       = 1'b0;
  assign avalon_ifh.writedata  = wdata_q;
  assign avalon_ifh.byteenable = 4'hF;
  assign unused_rdata          = ^avalon_ifh.readdata;

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Scoreboard bench for fb_pattern_writer on a 32x2 framebuffer at 0x100.
module tb_fb_pattern_writer;

  localparam int          HD   = 32;
  localparam int          VD   = 2;
  localparam int          NPIX = HD * VD;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic        busy;
  logic        done;
  logic [15:0] frame_count;

  avalon_if #(.DATA_BYTES(4)) bus ();

  fb_pattern_writer #(
    .HDISP     (HD),
    .VDISP     (VD),
    .BASE_ADDR (BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .avalon_ifh  (bus),
    .start       (start),
    .pattern     (pattern),
    .busy        (busy),
    .done        (done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        mon_e;
  logic [31:0] cap_a[$];
  logic [31:0] cap_d[$];
  int          acc_n = 0;
  int          first_acc = -1;
  int          last_acc = -1;
  int          done_n = 0;
  int          done_cyc = -1;
  bit          wr_rand = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] hold_a, hold_d;
  int          sc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_px(input int x, input int y,
                                           input logic [1:0] p, input logic [7:0] f);
    logic [2:0] b;
    b = 3'(x >> 7);
    case (p)
      2'd0:    return {8'h00, 8'(x), 8'(y), 8'h00};
      2'd1:    return {8'h00, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
      2'd2:    return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 32'h00FF_FFFF : 32'h0;
      default: return {8'h00, f, f, f};
    endcase
  endfunction

  task automatic push_frame(input logic [1:0] p, input logic [7:0] f);
    for (int yy = 0; yy < VD; yy++)
      for (int xx = 0; xx < HD; xx++)
        exp_q.push_back({BASE + 32'(4 * (yy * HD + xx)), model_px(xx, yy, p, f)});
  endtask

  task automatic reset_stats();
    cap_a.delete();
    cap_d.delete();
    acc_n     = 0;
    first_acc = -1;
    last_acc  = -1;
    done_n    = 0;
    done_cyc  = -1;
  endtask

  task automatic pulse_start(input logic [1:0] p, output int s);
    @(posedge clk); #1;
    start   = 1'b1;
    pattern = p;
    s       = cyc;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_n < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("done_reached", done_n, n);
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (acc_n < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (acc_n < n) chk("accept_timeout", acc_n, n);
  endtask

  // Waitrequest driver: held low unless random stalling is enabled.
  initial begin
    bus.readdata    = '0;
    bus.waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: pops the scoreboard on each accept, checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stall_write", 32'(bus.write), 32'd1);
        chk("stall_addr", bus.address, hold_a);
        chk("stall_data", bus.writedata, hold_d);
      end
      if (bus.write && !bus.waitrequest) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept: got addr %h, expected no write", bus.address);
        end else begin
          mon_e = exp_q.pop_front();
          chk("accept_addr", bus.address, mon_e.a);
          chk("accept_data", bus.writedata, mon_e.d);
        end
        cap_a.push_back(bus.address);
        cap_d.push_back(bus.writedata);
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        acc_n++;
      end
      hold   = bus.write && bus.waitrequest;
      hold_a = bus.address;
      hold_d = bus.writedata;
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_write", 32'(bus.write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_addr", bus.address, 32'd0);
    chk("rst_data", bus.writedata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Checker frame, no stalls
    reset_stats();
    push_frame(2'd2, 8'd0);
    pulse_start(2'd2, sc);
    wait_done(1, 500);
    repeat (3) @(posedge clk);
    chk("chk_accepts", acc_n, NPIX);
    chk("chk_first_lat", first_acc, sc + 1);
    chk("chk_consecutive", last_acc - first_acc, NPIX - 1);
    chk("chk_done_lat", done_cyc, last_acc + 1);
    chk("chk_done_once", done_n, 1);
    chk("chk_fc", 32'(frame_count), 32'd1);
    chk("chk_busy_low", 32'(busy), 32'd0);
    chk("chk_last_addr", cap_a[NPIX-1], 32'h0000_01FC);
    chk("chk_px15", cap_d[15], 32'h0000_0000);
    chk("chk_px16", cap_d[16], 32'h00FF_FFFF);
    chk("chk_queue_empty", exp_q.size(), 0);

    // Gradient frame with random stalls
    reset_stats();
    wr_rand = 1'b1;
    push_frame(2'd0, 8'd1);
    pulse_start(2'd0, sc);
    wait_done(1, 3000);
    wr_rand = 1'b0;
    repeat (3) @(posedge clk);
    chk("grad_accepts", acc_n, NPIX);
    chk("grad_px_5_1", cap_d[37], 32'h0005_0100);
    chk("grad_addr_5_1", cap_a[37], 32'h0000_0194);
    chk("grad_fc", 32'(frame_count), 32'd2);
    chk("grad_queue_empty", exp_q.size(), 0);

    // Start and pattern change mid-frame are ignored
    reset_stats();
    push_frame(2'd0, 8'd2);
    pulse_start(2'd0, sc);
    wait_acc(10, 200);
    @(posedge clk); #1;
    start   = 1'b1;
    pattern = 2'd1;
    @(posedge clk); #1;
    start   = 1'b0;
    wait_done(1, 500);
    repeat (4) @(posedge clk);
    chk("mid_accepts", acc_n, NPIX);
    chk("mid_done_once", done_n, 1);
    chk("mid_fc", 32'(frame_count), 32'd3);
    chk("mid_busy_low", 32'(busy), 32'd0);
    chk("mid_px_8_1", cap_d[40], 32'h0008_0100);
    chk("mid_queue_empty", exp_q.size(), 0);

    // Reset mid-frame, then a clean restart
    reset_stats();
    push_frame(2'd2, 8'd3);
    pulse_start(2'd2, sc);
    wait_acc(20, 200);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_write", 32'(bus.write), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_fc", 32'(frame_count), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    reset_stats();
    push_frame(2'd2, 8'd0);
    pulse_start(2'd2, sc);
    wait_done(1, 500);
    repeat (3) @(posedge clk);
    chk("restart_addr0", cap_a[0], 32'h0000_0100);
    chk("restart_data0", cap_d[0], 32'h0000_0000);
    chk("restart_accepts", acc_n, NPIX);
    chk("restart_fc", 32'(frame_count), 32'd1);
    chk("restart_queue_empty", exp_q.size(), 0);

`ifdef FB_WRITER_LOOP_EN
    // Looping: start held high, flat pattern over three frames
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_stats();
    push_frame(2'd3, 8'd0);
    push_frame(2'd3, 8'd1);
    push_frame(2'd3, 8'd2);
    @(posedge clk); #1;
    start   = 1'b1;
    pattern = 2'd3;
    wait_acc(2 * NPIX + 2, 1000);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, 1000);
    repeat (4) @(posedge clk);
    chk("loop_done_n", done_n, 3);
    chk("loop_accepts", acc_n, 3 * NPIX);
    chk("loop_f2_px7", cap_d[NPIX+7], 32'h0001_0101);
    chk("loop_fc", 32'(frame_count), 32'd3);
    chk("loop_busy_low", 32'(busy), 32'd0);
    chk("loop_queue_empty", exp_q.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
